ring_meas: RTL and testbench
============================

// Module: ring_meas
// PURPOSE
//  Producer of the ph_ring/ph_vld parameter stream consumed by the fracture threshold detector.
//  On each excitation trigger: skip a blanking interval of ADC samples, track the ring-down
//  waveform over a measurement window, then emit one ring amplitude word with a 1-cycle valid strobe.
//  Sits between the ADC sample interface and the app_top detection logic; runs entirely on clk_sys.
// PARAMETERS
//  DW        16   ADC sample width, two's complement; ph_ring width equals DW
//  CW        16   width of cfg_blank / cfg_win sample counters
// PORTS
//  clk_sys     in   1    system clock; single clock domain
//  rst_n       in   1    asynchronous active-low reset
//  adc_data    in   DW   signed ADC sample, qualified by adc_vld
//  adc_vld     in   1    sample strobe; only strobed cycles advance counters or trackers
//  trig        in   1    excitation trigger pulse, start of one measurement
//  cfg_blank   in   CW   samples discarded after trig (ringing settle time)
//  cfg_win     in   CW   samples measured after blanking
//  ph_ring     out  DW   unsigned ring amplitude, held until next result
//  ph_vld      out  1    1-cycle strobe, ph_ring valid on same cycle
//  stu_busy    out  1    high from accepted trig until the ph_vld cycle (inclusive)
// BEHAVIOUR
//  Reset: ph_ring=0, ph_vld=0, stu_busy=0, state=IDLE, counters=0, max=min=0.
//  FSM: IDLE -trig-> BLANK (cfg_blank!=0) or MEAS (cfg_blank==0); BLANK -cnt reaches cfg_blank-> MEAS;
//   MEAS -cnt reaches cfg_win-> DONE; DONE -> IDLE after 1 cycle (ph_vld=1 in DONE).
//  cfg_blank/cfg_win latched on the trig cycle; later config changes do not affect a running shot.
//  trig while stu_busy=1 ignored (no restart, no queue). trig in the same cycle as the DONE strobe is ignored.
//  Sample on the trig cycle itself is not counted; counting starts the cycle after trig.
//  BLANK: counter increments per adc_vld; samples discarded.
//  MEAS: first accepted sample loads max=min=sample; later samples update signed max/min.
//  Latency: ph_vld asserted exactly 1 cycle after the cycle accepting the last window sample.
//  ph_ring = max - min computed in DW+1 bits, result 0..2^DW-1 always fits in DW unsigned (no saturation).
//  cfg_win==0: BLANK->DONE directly, ph_ring=0, ph_vld still pulsed once.
//  adc_vld idle: FSM holds state indefinitely; no timeout.
//  rst_n asserted mid-shot: all state cleared immediately, no ph_vld emitted for that shot.
//  ph_ring updates only on ph_vld cycle; holds value otherwise.
// CONFIGURATION
//  RING_ABS_EN defined: ph_ring = max |sample| over window (absolute peak); |-2^(DW-1)| = 2^(DW-1)
//   fits unsigned DW; tracker keeps abs max only.
//  RING_ABS_EN undefined: ph_ring = max - min (peak-to-peak), as above.
//  All FSM timing, strobes and boundary rules identical in both builds.
// STRUCTURE
//  Shared package ring_pkg: FSM state encodings (IDLE/BLANK/MEAS/DONE as 2-bit localparams),
//   DW/CW default constants, common with the fracture detector's ph_ring width.
//  Sub-module ring_track: per-sample min/max (or abs max) tracker with load/update enables;
//   top holds FSM, counters, config latches and output registers.
// TESTING
//  1 blank=2 win=4, samples 100,-100 (blank) then 10,-20,30,5 -> ph_vld 1 cycle after 4th, ph_ring=50 (ABS: 30).
//  2 win=3, samples 32767,-32768,0 -> ph_ring=65535 (ABS: 32768); no wrap.
//  3 blank=0 win=0, trig -> ph_vld 1 cycle after trig... with ph_ring=0, stu_busy back to 0 after strobe.
//  4 second trig mid-MEAS and cfg_win changed to 1 mid-shot -> single ph_vld, original window length used.
//  5 adc_vld gaps (1 strobe per 3 cycles), win=2 -> only strobed samples counted; ph_vld timing per rule.
//  6 rst_n low during MEAS -> outputs 0 asynchronously, no ph_vld; next trig measures cleanly.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared constants and FSM state encoding for the ring amplitude producer.
// Widths match the fracture detector's ph_ring input.
package ring_pkg;

   localparam int RING_DW = 16;
   localparam int RING_CW = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_MEAS  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      BLANK = ST_BLANK,
      MEAS  = ST_MEAS,
      DONE  = ST_DONE
   } state_t;

endpackage

// File: rtl/ring_meas_if.sv
// ADC sample / trigger / config inputs and ring result outputs.
// master drives samples and config, slave is the measurement block.
interface ring_meas_if
   import ring_pkg::*;
#(
   parameter int DW = RING_DW,
   parameter int CW = RING_CW
) ();

   logic [DW-1:0] adc_data;
   logic          adc_vld;
   logic          trig;
   logic [CW-1:0] cfg_blank;
   logic [CW-1:0] cfg_win;
   logic [DW-1:0] ph_ring;
   logic          ph_vld;
   logic          stu_busy;

   modport master (
      output adc_data, adc_vld, trig, cfg_blank, cfg_win,
      input  ph_ring, ph_vld, stu_busy
   );

   modport slave (
      input  adc_data, adc_vld, trig, cfg_blank, cfg_win,
      output ph_ring, ph_vld, stu_busy
   );

endinterface

// File: rtl/ring_track.sv
// Per-sample waveform tracker: signed max/min, or abs peak with RING_ABS_EN.
// ring_o reflects the values after this cycle's update, so the last sample counts.
module ring_track #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          load_i,
   input  logic          upd_i,
   input  logic [DW-1:0] sample_i,
   output logic [DW-1:0] ring_o
);

`ifdef RING_ABS_EN

   localparam logic [DW-1:0] ONE = DW'(1);

   logic [DW-1:0] mag;
   logic [DW-1:0] amax_q, amax_d;

   // |-2^(DW-1)| wraps to 2^(DW-1), which is correct read as unsigned
   assign mag = sample_i[DW-1] ? (~sample_i + ONE) : sample_i;

   // Next absolute peak: clear per shot, load on first sample, then grow
   always_comb begin
      amax_d = amax_q;
      if (clr_i)
         amax_d = '0;
      else if (load_i)
         amax_d = mag;
      else if (upd_i && (mag > amax_q))
         amax_d = mag;
   end

   // Peak register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         amax_q <= '0;
      else
         amax_q <= amax_d;
   end

   assign ring_o = amax_d;

`else

   logic signed [DW-1:0] s;
   logic signed [DW-1:0] max_q, max_d;
   logic signed [DW-1:0] min_q, min_d;

   assign s = $signed(sample_i);

   // Next signed extremes: clear per shot, load on first sample, then widen
   always_comb begin
      max_d = max_q;
      min_d = min_q;
      if (clr_i) begin
         max_d = '0;
         min_d = '0;
      end else if (load_i) begin
         max_d = s;
         min_d = s;
      end else if (upd_i) begin
         if (s > max_q) max_d = s;
         if (s < min_q) min_d = s;
      end
   end

   // Extreme registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_q <= '0;
         min_q <= '0;
      end else begin
         max_q <= max_d;
         min_q <= min_d;
      end
   end

   // max >= min, so the true difference is 0..2^DW-1 and the low DW bits are exact
   assign ring_o = max_d - min_d;

`endif

endmodule

// File: rtl/ring_meas.sv
// Ring-down amplitude measurement: trig -> blank -> window -> one ph_vld strobe.
// RING_ABS_EN selects absolute-peak instead of peak-to-peak amplitude.
module ring_meas
   import ring_pkg::*;
#(
   parameter int DW = RING_DW,
   parameter int CW = RING_CW
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   ring_meas_if.slave  bus
);

   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [CW-1:0] blank_q, blank_d;
   logic [CW-1:0] win_q, win_d;
   logic [DW-1:0] ring_q, ring_d;
   logic          vld_q, vld_d;
   logic          busy_q, busy_d;
   logic          trk_clr, trk_load, trk_upd;
   logic [DW-1:0] trk_ring;

   assign cnt_inc = cnt_q + CNT_ONE;

   ring_track #(
      .DW (DW)
   ) u_track (
      .clk      (clk_sys),
      .rst_n    (rst_n),
      .clr_i    (trk_clr),
      .load_i   (trk_load),
      .upd_i    (trk_upd),
      .sample_i (bus.adc_data),
      .ring_o   (trk_ring)
   );

   // Shot sequencing, counters, config latches and next output values
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      blank_d  = blank_q;
      win_d    = win_q;
      ring_d   = ring_q;
      vld_d    = 1'b0;
      busy_d   = busy_q;
      trk_clr  = 1'b0;
      trk_load = 1'b0;
      trk_upd  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.trig) begin
               blank_d = bus.cfg_blank;
               win_d   = bus.cfg_win;
               cnt_d   = '0;
               busy_d  = 1'b1;
               trk_clr = 1'b1;
               if (bus.cfg_blank != '0) begin
                  state_d = BLANK;
               end else if (bus.cfg_win != '0) begin
                  state_d = MEAS;
               end else begin
                  state_d = DONE;
                  vld_d   = 1'b1;
                  ring_d  = '0;
               end
            end
         end
         BLANK: begin
            if (bus.adc_vld) begin
               if (cnt_inc == blank_q) begin
                  cnt_d = '0;
                  if (win_q != '0) begin
                     state_d = MEAS;
                  end else begin
                     state_d = DONE;
                     vld_d   = 1'b1;
                     ring_d  = '0;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         MEAS: begin
            if (bus.adc_vld) begin
               trk_load = (cnt_q == '0);
               trk_upd  = (cnt_q != '0);
               if (cnt_inc == win_q) begin
                  cnt_d   = '0;
                  state_d = DONE;
                  vld_d   = 1'b1;
                  ring_d  = trk_ring;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // FSM and registered outputs
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         blank_q <= '0;
         win_q   <= '0;
         ring_q  <= '0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blank_q <= blank_d;
         win_q   <= win_d;
         ring_q  <= ring_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.ph_ring  = ring_q;
   assign bus.ph_vld   = vld_q;
   assign bus.stu_busy = busy_q;

endmodule

// File: tb/tb_ring_meas.sv
// Randomized bench for ring_meas against a sample-list reference model.
// Build with +define+RING_ABS_EN to check the absolute-peak variant.
module tb_ring_meas;

   logic clk_sys = 1'b0;
   logic rst_n;

   int total = 0;
   int bad = 0;
   int pulse_cnt = 0;

   int win_s[$];
   int fixed[$];

   int          lat;
   int          pulses_seen;
   logic [15:0] ring_obs;
   bit          busy_ok;
   bit          post_ok;

   ring_meas_if bus ();

   ring_meas dut (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys)
      if (rst_n === 1'b1 && bus.ph_vld === 1'b1) pulse_cnt++;

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   function automatic int model();
      int hi, lo, m;
      if (win_s.size() == 0) return 0;
`ifdef RING_ABS_EN
      m = 0;
      foreach (win_s[i]) begin
         int a;
         a = (win_s[i] < 0) ? -win_s[i] : win_s[i];
         if (a > m) m = a;
      end
      return m;
`else
      hi = win_s[0];
      lo = win_s[0];
      foreach (win_s[i]) begin
         if (win_s[i] > hi) hi = win_s[i];
         if (win_s[i] < lo) lo = win_s[i];
      end
      m = hi - lo;
      return m;
`endif
   endfunction

   // Runs one shot; collects observations for the calling test to judge
   task automatic drive_shot(input int blank, input int win, input int gap,
                             input bit mid, input bit trig_in_done);
      int nv, iter, p0, v;
      logic [15:0] d;
      win_s.delete();
      busy_ok = 1;
      post_ok = 1;
      p0 = pulse_cnt;
      bus.trig = 1'b1;
      bus.cfg_blank = 16'(blank);
      bus.cfg_win = 16'(win);
      bus.adc_vld = 1'b1;
      bus.adc_data = 16'($urandom);
      step();
      bus.trig = 1'b0;
      nv = 0;
      iter = 0;
      while (nv < blank + win && iter < 2000) begin
         iter++;
         if (bus.stu_busy !== 1'b1) busy_ok = 0;
         if (gap == 0 || $urandom_range(0, gap) == 0) begin
            if (fixed.size() > 0) v = fixed.pop_front();
            else v = int'($signed(16'($urandom)));
            d = v[15:0];
            bus.adc_vld = 1'b1;
            bus.adc_data = d;
            if (nv >= blank) win_s.push_back(v);
            nv++;
            if (mid && nv == blank + 1) begin
               bus.trig = 1'b1;
               bus.cfg_win = 16'd1;
               bus.cfg_blank = 16'd0;
            end
         end else begin
            bus.adc_vld = 1'b0;
            bus.adc_data = 16'($urandom);
         end
         step();
         bus.trig = 1'b0;
      end
      bus.adc_vld = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         if (bus.ph_vld === 1'b1) begin
            lat = i;
            break;
         end
         step();
      end
      ring_obs = bus.ph_ring;
      if (trig_in_done) bus.trig = 1'b1;
      step();
      bus.trig = 1'b0;
      if (bus.stu_busy !== 1'b0 || bus.ph_vld !== 1'b0) post_ok = 0;
      step();
      if (bus.stu_busy !== 1'b0 || bus.ph_ring !== ring_obs) post_ok = 0;
      pulses_seen = pulse_cnt - p0;
   endtask

   task automatic test_reset();
      total++;
      if (bus.ph_ring !== 16'd0) begin
         bad++; $display("FAIL reset_ring got=%0d want=0", bus.ph_ring);
      end
      total++;
      if (bus.ph_vld !== 1'b0) begin
         bad++; $display("FAIL reset_vld got=%b want=0", bus.ph_vld);
      end
      total++;
      if (bus.stu_busy !== 1'b0) begin
         bad++; $display("FAIL reset_busy got=%b want=0", bus.stu_busy);
      end
   endtask

   task automatic test_vectors();
      int e;
      fixed = '{100, -100, 10, -20, 30, 5};
      drive_shot(2, 4, 0, 0, 0);
      e = model();
      total++;
      if (lat !== 1) begin
         bad++; $display("FAIL v1_latency got=%0d want=1", lat);
      end
      total++;
      if (int'(ring_obs) !== e) begin
         bad++; $display("FAIL v1_ring got=%0d want=%0d", ring_obs, e);
      end
      total++;
      if (!busy_ok || !post_ok) begin
         bad++; $display("FAIL v1_busy got=%0d/%0d want=1/1", busy_ok, post_ok);
      end
      fixed = '{32767, -32768, 0};
      drive_shot(0, 3, 0, 0, 0);
      e = model();
      total++;
      if (lat !== 1 || int'(ring_obs) !== e) begin
         bad++;
         $display("FAIL v2_extreme got=%0d lat=%0d want=%0d lat=1",
                  ring_obs, lat, e);
      end
      fixed.delete();
      drive_shot(0, 0, 0, 0, 0);
      total++;
      if (lat !== 1 || ring_obs !== 16'd0) begin
         bad++;
         $display("FAIL v3_zero_win got=%0d lat=%0d want=0 lat=1",
                  ring_obs, lat);
      end
      total++;
      if (pulses_seen !== 1 || !post_ok) begin
         bad++;
         $display("FAIL v3_single got=%0d post=%0d want=1 post=1",
                  pulses_seen, post_ok);
      end
   endtask

   task automatic test_mid_shot();
      int e;
      drive_shot(3, 5, 0, 1, 0);
      e = model();
      total++;
      if (pulses_seen !== 1) begin
         bad++; $display("FAIL mid_pulses got=%0d want=1", pulses_seen);
      end
      total++;
      if (lat !== 1 || int'(ring_obs) !== e) begin
         bad++;
         $display("FAIL mid_ring got=%0d lat=%0d want=%0d lat=1",
                  ring_obs, lat, e);
      end
   endtask

   task automatic test_gaps();
      int e;
      for (int k = 0; k < 3; k++) begin
         drive_shot(2, 2, 2, 0, 0);
         e = model();
         total++;
         if (lat !== 1 || int'(ring_obs) !== e || pulses_seen !== 1) begin
            bad++;
            $display("FAIL gaps got=%0d lat=%0d n=%0d want=%0d lat=1 n=1",
                     ring_obs, lat, pulses_seen, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      int e;
      drive_shot(1, 3, 0, 0, 1);
      e = model();
      total++;
      if (!post_ok || pulses_seen !== 1) begin
         bad++;
         $display("FAIL done_trig got=%0d n=%0d want=1 n=1",
                  post_ok, pulses_seen);
      end
      total++;
      if (int'(ring_obs) !== e) begin
         bad++; $display("FAIL b2b_ring1 got=%0d want=%0d", ring_obs, e);
      end
      drive_shot(0, 2, 0, 0, 0);
      e = model();
      total++;
      if (lat !== 1 || int'(ring_obs) !== e) begin
         bad++;
         $display("FAIL b2b_ring2 got=%0d lat=%0d want=%0d lat=1",
                  ring_obs, lat, e);
      end
   endtask

   task automatic test_reset_mid();
      int p0, e;
      p0 = pulse_cnt;
      bus.trig = 1'b1;
      bus.cfg_blank = 16'd1;
      bus.cfg_win = 16'd6;
      bus.adc_vld = 1'b1;
      bus.adc_data = 16'h1234;
      step();
      bus.trig = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.adc_data = 16'($urandom);
         step();
      end
      total++;
      if (bus.stu_busy !== 1'b1) begin
         bad++; $display("FAIL rmid_busy_before got=%b want=1", bus.stu_busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.ph_ring !== 16'd0 || bus.ph_vld !== 1'b0 || bus.stu_busy !== 1'b0) begin
         bad++;
         $display("FAIL rmid_async got=%0d/%b/%b want=0/0/0",
                  bus.ph_ring, bus.ph_vld, bus.stu_busy);
      end
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.adc_data = 16'($urandom);
         step();
      end
      bus.adc_vld = 1'b0;
      total++;
      if (pulse_cnt - p0 !== 0 || bus.stu_busy !== 1'b0) begin
         bad++;
         $display("FAIL rmid_no_vld got=%0d busy=%b want=0 busy=0",
                  pulse_cnt - p0, bus.stu_busy);
      end
      drive_shot(1, 3, 0, 0, 0);
      e = model();
      total++;
      if (lat !== 1 || int'(ring_obs) !== e || pulses_seen !== 1) begin
         bad++;
         $display("FAIL rmid_clean got=%0d lat=%0d want=%0d lat=1",
                  ring_obs, lat, e);
      end
   endtask

   task automatic test_random();
      int b, w, g, e;
      for (int k = 0; k < 12; k++) begin
         b = $urandom_range(0, 4);
         w = $urandom_range(0, 6);
         g = $urandom_range(0, 3);
         drive_shot(b, w, g, 0, 0);
         e = model();
         total++;
         if (lat !== 1 || int'(ring_obs) !== e || pulses_seen !== 1 ||
             !busy_ok || !post_ok) begin
            bad++;
            $display("FAIL rand b=%0d w=%0d got=%0d lat=%0d n=%0d want=%0d lat=1 n=1",
                     b, w, ring_obs, lat, pulses_seen, e);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.trig = 1'b0;
      bus.adc_vld = 1'b0;
      bus.adc_data = '0;
      bus.cfg_blank = '0;
      bus.cfg_win = '0;
      step();
      step();
      test_reset();
      rst_n = 1'b1;
      step();
      test_vectors();
      test_mid_shot();
      test_gaps();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
